pc_regfile: RTL

PC_REGFILE -- requirements
Module: pc_regfile

---
 rtl/pc_regfile.sv | 45 ++++
 1 files changed

// File: rtl/pc_regfile.sv
// pc_regfile: register file whose top register is the program counter, with bypassed registered read ports.
module pc_regfile #(
  parameter int WORD = 4,
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NREAD = 3,
  parameter int PC_STEP = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]      ra,
  output logic [NREAD*WORD*WIDTH-1:0]      rd,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            wa,
  input  logic [WORD*WIDTH-1:0]            wd,
  input  logic                             ib,
  input  logic [WORD*WIDTH-1:0]            bv,
  input  logic                             stall,
  output logic [WORD*WIDTH-1:0]            iout
);
  localparam int DW = WORD * WIDTH;
  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PCI = NREG - 1;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] pc, pc_next;
  logic          pcw;
  assign pc  = regs[PCI];
  assign pcw = we && wa == ADDR_WIDTH'(PCI);
  // A PC write outranks stall; the branch is only considered when nothing else claims the PC.
  always_comb pc_next = pcw ? wd : stall ? pc : ib ? pc + bv : pc + DW'(PC_STEP);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd   <= '0;
      iout <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == PCI) ? pc_next : (we && wa == ADDR_WIDTH'(i)) ? wd : regs[i];
      if (!stall)
        for (int k = 0; k < NREAD; k++)
          rd[k*DW +: DW] <= (we && wa == ra[k*ADDR_WIDTH +: ADDR_WIDTH]) ? wd : regs[ra[k*ADDR_WIDTH +: ADDR_WIDTH]];
      iout <= pcw ? wd : stall ? iout : pc;
    end
  end
endmodule
